// File: rtl/operand_reader_pkg.sv
// Shared sizing defaults and FSM encoding for the operand reader slice.
// Optional feature macro: OPR_BYPASS_EN (write-back bypass into CHECK).
package operand_reader_pkg;

    localparam int W_OPR_D  = 32;
    localparam int N_REG_D  = 32;
    localparam int W_ADDR_D = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/operand_reader_hazard_chk.sv
// Combinational RAW/WAW hazard detect and operand select for operand_reader.
// With OPR_BYPASS_EN a matching write-back both clears a source hazard and feeds data.
module opr_hazard_chk
    import operand_reader_pkg::*;
#(
    parameter int W_OPR  = W_OPR_D,
    parameter int N_REG  = N_REG_D,
    parameter int W_ADDR = W_ADDR_D
) (
    input  logic [W_ADDR-1:0]      i_rs1,
    input  logic [W_ADDR-1:0]      i_rs2,
    input  logic [W_ADDR-1:0]      i_rd,
    input  logic                   i_rd_we,
    input  logic [N_REG*W_OPR-1:0] i_rf_data,
    input  logic [N_REG-1:0]       i_rf_res,
    input  logic                   i_wb_valid,
    input  logic [W_ADDR-1:0]      i_wb_addr,
    input  logic [W_OPR-1:0]       i_wb_data,
    output logic                   o_hazard,
    output logic [W_OPR-1:0]       o_op1,
    output logic [W_OPR-1:0]       o_op2
);

    logic [W_OPR-1:0] w_cell [N_REG];
    logic             w_byp1;
    logic             w_byp2;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_haz_rd;

    for (genvar k = 0; k < N_REG; k++) begin : g_cell
        assign w_cell[k] = i_rf_data[k*W_OPR +: W_OPR];
    end

`ifdef OPR_BYPASS_EN
    assign w_byp1 = i_wb_valid && (i_wb_addr == i_rs1);
    assign w_byp2 = i_wb_valid && (i_wb_addr == i_rs2);
`else
    logic w_unused_wb;
    assign w_byp1      = 1'b0;
    assign w_byp2      = 1'b0;
    assign w_unused_wb = ^i_wb_data;
`endif

    assign w_haz1 = (i_rs1 != '0) && i_rf_res[i_rs1] && !w_byp1;
    assign w_haz2 = (i_rs2 != '0) && i_rf_res[i_rs2] && !w_byp2;

    // The cell re-reserves after a same-cycle write-back, so WAW is safe to clear.
    assign w_haz_rd = i_rd_we && (i_rd != '0) && i_rf_res[i_rd]
                    && !(i_wb_valid && (i_wb_addr == i_rd));

    assign o_hazard = w_haz1 || w_haz2 || w_haz_rd;

    assign o_op1 = (i_rs1 == '0) ? '0 : (w_byp1 ? i_wb_data : w_cell[i_rs1]);
    assign o_op2 = (i_rs2 == '0) ? '0 : (w_byp2 ? i_wb_data : w_cell[i_rs2]);

endmodule

// File: rtl/operand_reader.sv
// Operand read stage: latch request, wait out register hazards, reserve rd, issue.
// Optional feature macro: OPR_BYPASS_EN (handled inside opr_hazard_chk).
module operand_reader
    import operand_reader_pkg::*;
#(
    parameter int W_OPR  = W_OPR_D,
    parameter int N_REG  = N_REG_D,
    parameter int W_ADDR = W_ADDR_D
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [W_ADDR-1:0]      rs1_i,
    input  logic [W_ADDR-1:0]      rs2_i,
    input  logic [W_ADDR-1:0]      rd_i,
    input  logic                   rd_we_i,
    input  logic [N_REG*W_OPR-1:0] rf_data_i,
    input  logic [N_REG-1:0]       rf_res_i,
    input  logic                   wb_valid_i,
    input  logic [W_ADDR-1:0]      wb_addr_i,
    input  logic [W_OPR-1:0]       wb_data_i,
    output logic [N_REG-1:0]       w_reserve_o,
    output logic                   issue_valid_o,
    input  logic                   issue_ready_i,
    output logic [W_OPR-1:0]       op1_o,
    output logic [W_OPR-1:0]       op2_o,
    output logic [W_ADDR-1:0]      rd_o,
    output logic                   rd_we_o,
    output logic [15:0]            stall_cnt_o
);

    state_t             r_state;
    state_t             w_state_n;
    logic [W_ADDR-1:0]  r_rs1;
    logic [W_ADDR-1:0]  r_rs2;
    logic [W_ADDR-1:0]  r_rd;
    logic               r_rd_we;
    logic [W_OPR-1:0]   r_op1;
    logic [W_OPR-1:0]   r_op2;
    logic [N_REG-1:0]   r_wres;
    logic [15:0]        r_stall;
    logic               w_hazard;
    logic [W_OPR-1:0]   w_op1;
    logic [W_OPR-1:0]   w_op2;
    logic               w_idle;
    logic               w_accept;
    logic               w_take;
    logic               w_stall;
    logic [N_REG-1:0]   w_onehot;

    opr_hazard_chk #(
        .W_OPR  (W_OPR),
        .N_REG  (N_REG),
        .W_ADDR (W_ADDR)
    ) u_hazard_chk (
        .i_rs1      (r_rs1),
        .i_rs2      (r_rs2),
        .i_rd       (r_rd),
        .i_rd_we    (r_rd_we),
        .i_rf_data  (rf_data_i),
        .i_rf_res   (rf_res_i),
        .i_wb_valid (wb_valid_i),
        .i_wb_addr  (wb_addr_i),
        .i_wb_data  (wb_data_i),
        .o_hazard   (w_hazard),
        .o_op1      (w_op1),
        .o_op2      (w_op2)
    );

    always_comb begin
        w_onehot       = '0;
        w_onehot[r_rd] = 1'b1;
    end

    always_comb begin
        w_state_n = r_state;
        w_idle    = 1'b0;
        w_accept  = 1'b0;
        w_take    = 1'b0;
        w_stall   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_idle = 1'b1;
                if (req_valid_i) begin
                    w_accept  = 1'b1;
                    w_state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                end else begin
                    w_take    = 1'b1;
                    w_state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_ready_i) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_rd_we <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_wres  <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                r_rs1   <= rs1_i;
                r_rs2   <= rs2_i;
                r_rd    <= rd_i;
                r_rd_we <= rd_we_i;
            end
            if (w_take) begin
                r_op1 <= w_op1;
                r_op2 <= w_op2;
            end
            // One-cycle reserve pulse, visible in the first ISSUE cycle.
            r_wres <= (w_take && r_rd_we && (r_rd != '0)) ? w_onehot : '0;
            if (w_stall && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
        end
    end

    assign req_ready_o   = w_idle && !rst;
    assign issue_valid_o = (r_state == S_ISSUE);
    assign w_reserve_o   = r_wres;
    assign op1_o         = r_op1;
    assign op2_o         = r_op2;
    assign rd_o          = r_rd;
    assign rd_we_o       = r_rd_we;
    assign stall_cnt_o   = r_stall;

endmodule
